// File: rtl/rtype_exec_stage_pkg.sv
// Shared definitions for the R-type execute stage: instruction field
// positions, opcode/funct encodings, ALU operation enum and the decoder.
package rtype_exec_stage_pkg;

    // Instruction field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Opcode and funct encodings
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // ALU_NONE marks an unsupported instruction
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_NONE
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    var_shift;  // shift amount comes from rs value, not shamt
    } dec_t;

    // Map opcode/funct to an ALU operation; anything else is ALU_NONE
    function automatic dec_t decode_inst(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.op        = ALU_NONE;
        d.var_shift = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  d.op = ALU_ADD;
                FN_ADDU: d.op = ALU_ADDU;
                FN_SUB:  d.op = ALU_SUB;
                FN_SUBU: d.op = ALU_SUBU;
                FN_AND:  d.op = ALU_AND;
                FN_OR:   d.op = ALU_OR;
                FN_XOR:  d.op = ALU_XOR;
                FN_NOR:  d.op = ALU_NOR;
                FN_SLT:  d.op = ALU_SLT;
                FN_SLTU: d.op = ALU_SLTU;
                FN_SLL:  d.op = ALU_SLL;
                FN_SRL:  d.op = ALU_SRL;
                FN_SRA:  d.op = ALU_SRA;
                FN_SLLV: begin d.op = ALU_SLL; d.var_shift = 1'b1; end
                FN_SRLV: begin d.op = ALU_SRL; d.var_shift = 1'b1; end
                FN_SRAV: begin d.op = ALU_SRA; d.var_shift = 1'b1; end
                default: d.op = ALU_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rtype_exec_stage_alu.sv
// Combinational ALU for the supported R-type operations. B is the shifted
// operand; shamt is already selected by the caller. ALU_NONE yields F=0.
module rtype_alu
    import rtype_exec_stage_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    input  logic [3:0]  op,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [31:0]        sum;
    logic [31:0]        diff;

    // Signed overflow: operands agree in sign but the sum does not
    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    // Signed overflow: operands differ in sign and the difference takes b's sign
    function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        return (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    assign a_s  = A;
    assign b_s  = B;
    assign sum  = A + B;
    assign diff = A - B;

    // Operation select, flags derived from the selected result
    always_comb begin
        F  = 32'h0;
        OF = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD:  begin F = sum;  OF = add_ovf(A, B, sum);  end
            ALU_ADDU: F = sum;
            ALU_SUB:  begin F = diff; OF = sub_ovf(A, B, diff); end
            ALU_SUBU: F = diff;
            ALU_AND:  F = A & B;
            ALU_OR:   F = A | B;
            ALU_XOR:  F = A ^ B;
            ALU_NOR:  F = ~(A | B);
            ALU_SLT:  F = {31'h0, (a_s < b_s)};
            ALU_SLTU: F = {31'h0, (A < B)};
            ALU_SLL:  F = B << shamt;
            ALU_SRL:  F = B >> shamt;
            ALU_SRA:  F = b_s >>> shamt;
            default:  F = 32'h0;
        endcase
        ZF = (F == 32'h0);
    end

endmodule

// File: rtl/rtype_exec_stage.sv
// Two-stage MIPS R-type datapath: ID (decode + register read with
// forwarding from EX/WB) then EX/WB (ALU + register write + status outputs).
module rtype_exec_stage
    import rtype_exec_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clka,
    input  logic             Reset,
    input  logic [31:0]      InstCode,
    input  logic             Inst_Valid,
    output logic [31:0]      ALU_F,
    output logic             ZF,
    output logic             OF,
    output logic             WB_En,
    output logic [4:0]       WB_Addr,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired_Cnt,
    input  logic [4:0]       Dbg_Addr,
    output logic [31:0]      Dbg_Data
);

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // ID stage decode signals
    logic [4:0]  rs_f, rt_f, rd_f, sh_f;
    dec_t        dec;
    logic [31:0] rs_val, rt_val;

    // ID -> EX/WB pipeline registers
    logic        vld_p0_q, vld_p0_d;
    alu_op_e     op_p0_q, op_p0_d;
    logic        var_p0_q, var_p0_d;
    logic [4:0]  rd_p0_q, rd_p0_d;
    logic [4:0]  sh_p0_q, sh_p0_d;
    logic [31:0] a_p0_q, a_p0_d;
    logic [31:0] b_p0_q, b_p0_d;

    // EX/WB signals and registered outputs
    logic [4:0]       sh_eff;
    logic [31:0]      alu_f;
    logic             alu_zf, alu_of;
    logic             we_ex;
    logic [31:0]      alu_f_q, alu_f_d;
    logic             zf_q, zf_d;
    logic             of_q, of_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ID: decode fields and read operands, forwarding the EX/WB result
    always_comb begin
        rs_f = InstCode[RS_MSB:RS_LSB];
        rt_f = InstCode[RT_MSB:RT_LSB];
        rd_f = InstCode[RD_MSB:RD_LSB];
        sh_f = InstCode[SHAMT_MSB:SHAMT_LSB];
        dec  = decode_inst(InstCode[OP_MSB:OP_LSB], InstCode[FUNCT_MSB:FUNCT_LSB]);

        if (rs_f == 5'd0)                     rs_val = 32'h0;
        else if (we_ex && rd_p0_q == rs_f)    rs_val = alu_f;
        else                                  rs_val = rf_q[rs_f];

        if (rt_f == 5'd0)                     rt_val = 32'h0;
        else if (we_ex && rd_p0_q == rt_f)    rt_val = alu_f;
        else                                  rt_val = rf_q[rt_f];

        vld_p0_d = Inst_Valid;
        op_p0_d  = dec.op;
        var_p0_d = dec.var_shift;
        rd_p0_d  = rd_f;
        sh_p0_d  = sh_f;
        a_p0_d   = rs_val;
        b_p0_d   = rt_val;
    end

    // EX/WB: the variable shifts take their amount from the rs operand
    assign sh_eff = var_p0_q ? a_p0_q[4:0] : sh_p0_q;

    rtype_alu u_alu (
        .A     (a_p0_q),
        .B     (b_p0_q),
        .shamt (sh_eff),
        .op    (op_p0_q),
        .F     (alu_f),
        .ZF    (alu_zf),
        .OF    (alu_of)
    );

    // EX/WB: write enable and next values of the status outputs; bubbles hold ALU_F/ZF/OF
    always_comb begin
        we_ex     = vld_p0_q && (op_p0_q != ALU_NONE) && (rd_p0_q != 5'd0) && !alu_of;
        alu_f_d   = alu_f_q;
        zf_d      = zf_q;
        of_d      = of_q;
        wb_addr_d = wb_addr_q;
        if (vld_p0_q) begin
            alu_f_d   = alu_f;
            zf_d      = alu_zf;
            of_d      = alu_of;
            wb_addr_d = rd_p0_q;
        end
        wb_en_d   = we_ex;
        illegal_d = vld_p0_q && (op_p0_q == ALU_NONE);
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, vld_p0_q};
    end

    // Register file next state: single write port from EX/WB
    always_comb begin
        rf_d = rf_q;
        if (we_ex) rf_d[rd_p0_q] = alu_f;
    end

    // Control, status and register file state with synchronous reset
    always_ff @(posedge Clka) begin
        if (Reset) begin
            vld_p0_q  <= 1'b0;
            alu_f_q   <= 32'h0;
            zf_q      <= 1'b1;
            of_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            alu_f_q   <= alu_f_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            rf_q      <= rf_d;
        end
    end

    // ID data payload; qualified by vld_p0_q so it needs no reset
    always_ff @(posedge Clka) begin
        op_p0_q  <= op_p0_d;
        var_p0_q <= var_p0_d;
        rd_p0_q  <= rd_p0_d;
        sh_p0_q  <= sh_p0_d;
        a_p0_q   <= a_p0_d;
        b_p0_q   <= b_p0_d;
    end

    assign ALU_F       = alu_f_q;
    assign ZF          = zf_q;
    assign OF          = of_q;
    assign WB_En       = wb_en_q;
    assign WB_Addr     = wb_addr_q;
    assign Illegal     = illegal_q;
    assign Retired_Cnt = cnt_q;
    assign Dbg_Data    = (Dbg_Addr == 5'd0) ? 32'h0 : rf_q[Dbg_Addr];

endmodule

// File: doc/rtype_exec_stage.md
Name: rtype_exec_stage

Overview:
- Downstream consumer of the instruction-fetch stage: takes the 32-bit InstCode word each cycle, decodes MIPS R-type instructions, reads a 32x32 register file, executes in an ALU, and writes back.
- Two-stage pipeline: ID (decode + register read) then EX/WB (ALU + write-back), with forwarding from EX/WB into ID.
- Exposes ALU result, flags, write-back info, retire count and a debug read port for board display and benches.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clka  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstCode  in  32  instruction word from fetch stage.
- Inst_Valid  in  1  InstCode is meaningful this cycle; tie to 1 when fetch runs free.
- ALU_F  out  32  EX/WB result of the most recent executed instruction.
- ZF  out  1  ALU_F == 0.
- OF  out  1  signed overflow on add/sub.
- WB_En  out  1  register write performed this cycle.
- WB_Addr  out  5  destination register of that write.
- Illegal  out  1  instruction in EX/WB is not a supported R-type.
- Retired_Cnt  out  CNT_W  count of instructions that completed EX/WB.
- Dbg_Addr  in  5  debug register select.
- Dbg_Data  out  32  combinational read of register Dbg_Addr; $0 reads 0.

Behaviour:
- Reset is synchronous and active-high. While Reset=1 at an edge: all 32 registers cleared to 0; ID and EX/WB valid bits cleared; ALU_F=0, ZF=1, OF=0, WB_En=0, WB_Addr=0, Illegal=0, Retired_Cnt=0. Reset mid-stream discards in-flight instructions and never writes the register file.
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]. Supported only when op=0.
- Supported funct values: 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu, 00 sll, 02 srl, 03 sra, 04 sllv, 06 srlv, 07 srav.
- Shift amount: shamt for sll/srl/sra; rs[4:0] for the variable forms. Shifted operand is rt.
- Edge N: if Inst_Valid=1, ID captures the decoded fields plus rs/rt operand values; otherwise ID becomes a bubble.
- Edge N+1: EX/WB registers the result and outputs and writes rd. Latency from InstCode to ALU_F is 2 edges; throughput is 1 instruction per cycle with no stalls.
- Forwarding: if the EX/WB instruction will write register r this edge, ID operand captures for r take the ALU result, not the stale file value. Back-to-back dependencies therefore need no bubble.
- Write enable = valid AND supported AND rd!=0 AND NOT(add/sub overflow). Writes to $0 are ignored.
- Overflow: add and sub set OF=1 on signed overflow and suppress the write. addu and subu never set OF.
- slt and sltu produce 32'h1 or 32'h0.
- Unsupported instructions (op!=0 or unknown funct): Illegal=1, no write, ALU_F=0, ZF=1. They still count as retired.
- Bubbles: WB_En=0, Illegal=0; ALU_F, ZF and OF hold their previous values; counter does not increment.
- Retired_Cnt increments once per valid instruction leaving EX/WB and wraps from all-ones to 0.
- InstCode 0x00000000 (sll $0,$0,0) is a legal nop: retires, ALU_F=0, WB_En=0.

Decomposition:
- Shared package holds the opcode/funct localparams, the ALU operation enum, and the field bit positions.
- Natural sub-module: rtype_alu, purely combinational; inputs A, B, shamt, op; outputs F, ZF, OF.
- The register file stays inline.

Test Plan:
- Reset, then InstCode=0x00000000 for 4 cycles -> WB_En=0, ALU_F=0, ZF=1, Retired_Cnt counts 1..3 after the 2-cycle fill.
- 0x00000827 (nor $1,$0,$0) then 0x00211021 (addu $2,$1,$1) back-to-back -> ALU_F=0xFFFFFFFF, then 0xFFFFFFFE via forwarding; Dbg_Addr=2 -> Dbg_Data=0xFFFFFFFE.
- After $1 set: 0x00012042 (srl $4,$1,1) then 0x00842820 (add $5,$4,$4) -> $4=0x7FFFFFFF; second instruction OF=1, WB_En=0, $5 reads 0.
- 0x0020302A (slt $6,$1,$0) -> $6=1; 0x0020302B (sltu $6,$1,$0) -> $6=0, ZF=1.
- InstCode=0x8C010000 (lw) -> Illegal=1, no write, Retired_Cnt increments; Inst_Valid=0 for 1 cycle -> bubble, outputs hold.
- Assert Reset in the cycle after nor $1 enters ID -> $1 stays 0, Retired_Cnt=0, all outputs at reset values.
